vga_tile_scan: RTL and testbench
================================

// Module: vga_tile_scan
// PURPOSE
//  VGA raster generator and pixel fetcher that reads the 64x8 tile/colour RAM.
//  It drives read_addr from the beam position and takes q one clock later.
//  It delay-matches sync and blanking to the RAM's 1-cycle read latency, then
//  emits registered RGB332 pixels plus hsync/vsync to the DAC pins.
//  Sits directly downstream of the RAM: read_addr -> RAM, RAM q -> ram_q.
// PARAMETERS
//  H_ACTIVE  640  visible pixels per line
//  H_FP      16   horizontal front porch, pixels
//  H_SYNC    96   hsync width, pixels
//  H_BP      48   horizontal back porch (H_TOTAL = sum = 800)
//  V_ACTIVE  480  visible lines per frame
//  V_FP      10   vertical front porch, lines
//  V_SYNC    2    vsync width, lines
//  V_BP      33   vertical back porch (V_TOTAL = sum = 525)
//  SYNC_POL  0    active level of hsync/vsync (0 = active-low)
//  X_SHIFT   7    tile column = hcnt >> X_SHIFT, low 3 bits used
//  Y_SHIFT   6    tile row    = vcnt >> Y_SHIFT, low 3 bits used
// PORTS
//  clk          in   1   pixel clock; single clock domain
//  rst_n        in   1   asynchronous, active-low reset
//  read_addr    out  6   RAM read address = {row[2:0], col[2:0]}
//  ram_q        in   8   RAM read data, valid 1 clk after read_addr
//  rgb          out  8   pixel RGB332; 8'h00 outside active area
//  hsync        out  1   horizontal sync
//  vsync        out  1   vertical sync
//  de           out  1   display enable, high on visible pixels
//  frame_start  out  1   1-clk pulse, aligned with pixel (0,0) at outputs
// BEHAVIOUR
//  Reset (async assert, sync release): hcnt=0, vcnt=0, all stage regs cleared.
//    Outputs: rgb=0, de=0, frame_start=0, hsync=vsync=~SYNC_POL (inactive).
//  Counters: hcnt 0..H_TOTAL-1 increments every clk and wraps to 0.
//    vcnt increments when hcnt wraps; vcnt wraps 0 after V_TOTAL-1 (frame end).
//  Stage 0, combinational from counters:
//    active = hcnt<H_ACTIVE && vcnt<V_ACTIVE
//    hs0 = hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
//    vs0 = vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
//    read_addr = {vcnt[Y_SHIFT+2:Y_SHIFT], hcnt[X_SHIFT+2:X_SHIFT]}; bit slices wrap mod 8.
//  Stage 1 regs capture active, hs0, vs0 and (hcnt==0&&vcnt==0).
//    This is the same edge at which the RAM registers q.
//  Stage 2 (output) regs:
//    rgb <= de1 ? ram_q : 8'h00; de/frame_start <= stage-1 copies.
//    hsync <= hs1 ^ ~SYNC_POL; vsync likewise.
//  Latency: counter value at edge N appears on outputs after edge N+2.
//    All outputs are mutually aligned; no output is combinational.
//  read_addr is driven during blanking too; that data is masked by de1=0.
//  Simultaneous hcnt and vcnt wrap: both go to 0 on the same edge.
//    frame_start fires exactly once per frame.
//  Reset mid-frame: clears immediately; restart at (0,0).
//    Stale ram_q is never shown, because de1=0 for the first output cycle.
//  RAM write collisions are the writer's concern.
//    Same-address read/write returns old data, which is acceptable for display.
// STRUCTURE
//  Package vga_pkg holds the timing localparams:
//    H_TOTAL, V_TOTAL, and HS_START/HS_END/VS_START/VS_END derived from the parameters.
//  Natural sub-module: vga_timing, which contains counters + stage-0 decode.
//    Outputs: hcnt, vcnt, active, hs0, vs0, sof.
//    vga_tile_scan adds the address map and the 2-stage alignment pipe.
// TESTING (bench includes a behavioural 64x8 RAM model, 1-cycle registered read)
//  1. Reset held, then released -> rgb=0, de=0, hsync=vsync=1.
//     2nd edge after release -> de=1, frame_start=1, rgb=ram[0].
//  2. Preload ram[i]=i.
//     Pixel x=128,y=0 -> rgb=8'h01. x=639,y=479 -> rgb=ram[{3'd7,3'd4}]=8'h3C. x=640 -> rgb=0, de=0.
//  3. One line -> hsync low for exactly 96 clks, starting at output pixel 656.
//     Line period is 800 clks; de high for 640 clks.
//  4. One frame -> vsync low for lines 490..491 (1600 clks).
//     frame_start period = 420000 clks.
//  5. Assert rst_n low at pixel (300,200) for 3 clks.
//     Outputs go to reset values immediately; next frame_start comes 2 clks after release.
//  6. Rewrite ram[5] to 8'hFF mid-frame, then watch the next line through tile col 5 row 0.
//     rgb=8'hFF from x=640 onward... not visible.
//     Use col 4: x=512..639 show the new value on lines after the write.

Source files
------------

// File: rtl/vga_tile_scan_pkg.sv
// Shared timing defaults, widths and helpers for the tile-scanning VGA raster generator.
// Derived totals and sync windows are kept here so every file agrees on them.
package vga_tile_scan_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_X_SHIFT  = 7;
    localparam int DEF_Y_SHIFT  = 6;

    localparam int H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int HS_END   = HS_START + DEF_H_SYNC;
    localparam int VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int VS_END   = VS_START + DEF_V_SYNC;

    // Counters are sized for totals up to 4096 and shifts up to 9.
    localparam int CNT_W  = 12;
    localparam int ADDR_W = 6;
    localparam int PIX_W  = 8;

    typedef struct packed {
        logic active;
        logic hs;
        logic vs;
        logic sof;
    } vga_ctl_t;

    function automatic logic [ADDR_W-1:0] tile_addr(input logic [2:0] row,
                                                    input logic [2:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/vga_tile_scan_if.sv
// Pixel-side bundle: RAM read port towards the tile RAM and the DAC pin outputs.
// The scanner is the master; the RAM/DAC side is the slave.
interface vga_tile_scan_if;
    import vga_tile_scan_pkg::*;

    logic [ADDR_W-1:0] read_addr;
    logic [PIX_W-1:0]  ram_q;
    logic [PIX_W-1:0]  rgb;
    logic              hsync;
    logic              vsync;
    logic              de;
    logic              frame_start;

    modport master (
        output read_addr,
        input  ram_q,
        output rgb,
        output hsync,
        output vsync,
        output de,
        output frame_start
    );

    modport slave (
        input  read_addr,
        output ram_q,
        input  rgb,
        input  hsync,
        input  vsync,
        input  de,
        input  frame_start
    );

endinterface

// File: rtl/vga_tile_scan_timing.sv
// Beam position counters plus the combinational stage-0 decode of active area,
// sync windows and start-of-frame.
module vga_tile_scan_timing
    import vga_tile_scan_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [CNT_W-1:0] o_hcnt,
    output logic [CNT_W-1:0] o_vcnt,
    output vga_ctl_t         o_ctl
);

    localparam logic [CNT_W-1:0] HT_M1 = CNT_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [CNT_W-1:0] VT_M1 = CNT_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [CNT_W-1:0] HA    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] VA    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_S  = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_E  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_S  = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_E  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic             w_h_wrap;
    logic             w_v_wrap;

    assign w_h_wrap = (r_hcnt == HT_M1);
    assign w_v_wrap = (r_vcnt == VT_M1);

    // At the last pixel of the last line both counters return to 0 on one edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (w_h_wrap) begin
            r_hcnt <= '0;
            r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
        end else begin
            r_hcnt <= r_hcnt + 1'b1;
        end
    end

    always_comb begin
        o_ctl        = '0;
        o_ctl.active = (r_hcnt < HA) && (r_vcnt < VA);
        o_ctl.hs     = (r_hcnt >= HS_S) && (r_hcnt < HS_E);
        o_ctl.vs     = (r_vcnt >= VS_S) && (r_vcnt < VS_E);
        o_ctl.sof    = (r_hcnt == '0) && (r_vcnt == '0);
    end

    assign o_hcnt = r_hcnt;
    assign o_vcnt = r_vcnt;

endmodule

// File: rtl/vga_tile_scan.sv
// VGA raster generator fetching RGB332 tiles from a 64x8 RAM with 1-cycle read latency;
// sync and blanking are delayed to line up with the returned pixel data.
module vga_tile_scan
    import vga_tile_scan_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0,
    parameter int X_SHIFT  = DEF_X_SHIFT,
    parameter int Y_SHIFT  = DEF_Y_SHIFT
) (
    input  logic            clk,
    input  logic            rst_n,
    vga_tile_scan_if.master bus
);

    function automatic logic [PIX_W-1:0] pix_mask(input logic vld,
                                                  input logic [PIX_W-1:0] q);
        return vld ? q : '0;
    endfunction

    logic [CNT_W-1:0] w_hcnt;
    logic [CNT_W-1:0] w_vcnt;
    vga_ctl_t         w_ctl_p0;
    logic [2:0]       w_col;
    logic [2:0]       w_row;

    vga_tile_scan_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP)
    ) u_timing (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_hcnt (w_hcnt),
        .o_vcnt (w_vcnt),
        .o_ctl  (w_ctl_p0)
    );

    // Tile coordinates wrap modulo 8; blanking addresses are fetched but masked later.
    assign w_col          = 3'(w_hcnt >> X_SHIFT);
    assign w_row          = 3'(w_vcnt >> Y_SHIFT);
    assign bus.read_addr  = tile_addr(w_row, w_col);

    // Stage 1: control captured on the same edge the RAM registers q.
    vga_ctl_t r_ctl_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ctl_p1 <= '0;
        end else begin
            r_ctl_p1 <= w_ctl_p0;
        end
    end

    // Stage 2: registered pins, all aligned to the pixel whose data arrives on ram_q.
    logic [PIX_W-1:0] r_rgb_p2;
    logic             r_vld_p2;
    logic             r_sof_p2;
    logic             r_hsync_p2;
    logic             r_vsync_p2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb_p2   <= '0;
            r_vld_p2   <= 1'b0;
            r_sof_p2   <= 1'b0;
            r_hsync_p2 <= ~SYNC_POL;
            r_vsync_p2 <= ~SYNC_POL;
        end else begin
            r_rgb_p2   <= pix_mask(r_ctl_p1.active, bus.ram_q);
            r_vld_p2   <= r_ctl_p1.active;
            r_sof_p2   <= r_ctl_p1.sof;
            r_hsync_p2 <= r_ctl_p1.hs ^ ~SYNC_POL;
            r_vsync_p2 <= r_ctl_p1.vs ^ ~SYNC_POL;
        end
    end

    assign bus.rgb         = r_rgb_p2;
    assign bus.de          = r_vld_p2;
    assign bus.frame_start = r_sof_p2;
    assign bus.hsync       = r_hsync_p2;
    assign bus.vsync       = r_vsync_p2;

endmodule

// File: tb/tb_vga_tile_scan.sv
// Bench for vga_tile_scan on a shrunken raster, with a registered-read RAM model and
// a raster model that derives every expected pin value from the pixel index.
module tb_vga_tile_scan;

    localparam int HA = 40, HFP = 4, HSW = 6, HBP = 6;
    localparam int VA = 24, VFP = 2, VSW = 2, VBP = 3;
    localparam int XS = 2, YS = 1;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_tile_scan_if bus();

    vga_tile_scan #(
        .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSW), .H_BP (HBP),
        .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSW), .V_BP (VBP),
        .SYNC_POL (1'b0), .X_SHIFT (XS), .Y_SHIFT (YS)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Tile RAM with one clock of read latency.
    logic [7:0] mem [64];
    always @(posedge clk) bus.ram_q <= mem[bus.read_addr];

    int checks = 0;
    int failures = 0;
    int e = 0;
    int prev_pix = 0;
    logic [7:0] mdl [64];
    logic [7:0] mdl_prev [64];
    bit ident = 1'b0;
    bit chk_col4 = 1'b0;
    bit agg_on = 1'b0;
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at e=%0d", tag, obs, exp, e);
        end
    endtask

    function automatic int tile(input int x, input int y);
        return (((y >> YS) % 8) * 8) + ((x >> XS) % 8);
    endfunction

    task automatic check_reset_pins(input string tag);
        chk({tag, "_rgb"}, 32'(bus.rgb), 32'h0);
        chk({tag, "_de"}, 32'(bus.de), 32'h0);
        chk({tag, "_hsync"}, 32'(bus.hsync), 32'h1);
        chk({tag, "_vsync"}, 32'(bus.vsync), 32'h1);
        chk({tag, "_fs"}, 32'(bus.frame_start), 32'h0);
    endtask

    task automatic check_pixel();
        int n, x, y, a, cx, cy;
        bit vis, hs_in, vs_in;
        logic [7:0] exp_rgb;
        cx = e % HT;
        cy = (e / HT) % VT;
        chk("read_addr", 32'(bus.read_addr), 32'(tile(cx, cy)));
        if (e < 2) begin
            check_reset_pins("first_edge");
            return;
        end
        n = e - 2;
        x = n % HT;
        y = (n / HT) % VT;
        a = tile(x, y);
        vis = (x < HA) && (y < VA);
        hs_in = (x >= HA + HFP) && (x < HA + HFP + HSW);
        vs_in = (y >= VA + VFP) && (y < VA + VFP + VSW);
        exp_rgb = !vis ? 8'h00 : ((n < prev_pix) ? mdl_prev[a] : mdl[a]);
        chk("rgb", 32'(bus.rgb), 32'(exp_rgb));
        chk("de", 32'(bus.de), 32'(vis));
        chk("hsync", 32'(bus.hsync), 32'(!hs_in));
        chk("vsync", 32'(bus.vsync), 32'(!vs_in));
        chk("frame_start", 32'(bus.frame_start), 32'(x == 0 && y == 0));
        if (ident && x == 4 && y == 0)   chk("spot_col1", 32'(bus.rgb), 32'h01);
        if (ident && x == 39 && y == 23) chk("spot_last", 32'(bus.rgb), 32'h19);
        if (ident && x == 40 && y == 0) begin
            chk("spot_blank_rgb", 32'(bus.rgb), 32'h00);
            chk("spot_blank_de", 32'(bus.de), 32'h0);
        end
        if (chk_col4 && x == 16 && y == 16) chk("col4_new", 32'(bus.rgb), 32'hFF);
        if (agg_on && n < FRAME) begin
            de_cnt += int'(bus.de);
            hs_cnt += int'(!bus.hsync);
            vs_cnt += int'(!bus.vsync);
            fs_cnt += int'(bus.frame_start);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        e++;
        if (rst_n) check_pixel();
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        mdl_prev = mdl;
        prev_pix = e;
        mem[a] = d;
        mdl[a] = d;
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'(i);
            mdl[i] = 8'(i);
        end
        ident = 1'b1;

        // Reset held: pins at inactive levels.
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check_reset_pins("reset_hold");
        chk("reset_addr", 32'(bus.read_addr), 32'h0);

        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        agg_on = 1'b1;
        tick();
        tick();
        chk("first_de", 32'(bus.de), 32'h1);
        chk("first_fs", 32'(bus.frame_start), 32'h1);
        while (e < FRAME + 1) tick();
        agg_on = 1'b0;
        chk("agg_de", 32'(de_cnt), 32'(HA * VA));
        chk("agg_hsync_low", 32'(hs_cnt), 32'(HSW * VT));
        chk("agg_vsync_low", 32'(vs_cnt), 32'(VSW * HT));
        chk("agg_frame_start", 32'(fs_cnt), 32'h1);
        ident = 1'b0;

        // Fresh random contents for the whole RAM.
        mdl_prev = mdl;
        prev_pix = e;
        for (int i = 0; i < 64; i++) begin
            v = 8'($urandom);
            mem[i] = v;
            mdl[i] = v;
        end
        repeat (20) tick();

        // Rewrite tile (row 0, col 4) mid-frame; it reappears on lines 16..17.
        while (((e - 2) % FRAME) != 5 * HT) tick();
        wr(4, 8'hFF);
        chk_col4 = 1'b1;
        while (((e - 2) % FRAME) != 17 * HT) tick();
        chk_col4 = 1'b0;

        // Random single-byte writes at random moments.
        for (int k = 0; k < 25; k++) begin
            repeat ($urandom_range(3, 150)) tick();
            wr(int'($urandom_range(0, 63)), 8'($urandom));
        end
        repeat (100) tick();

        // Mid-frame reset while the beam is in the visible area.
        while (((e - 2) % FRAME) != 12 * HT + 30) tick();
        chk("pre_reset_de", 32'(bus.de), 32'h1);
        rst_n = 1'b0;
        #1;
        check_reset_pins("async_reset");
        chk("async_reset_addr", 32'(bus.read_addr), 32'h0);
        repeat (3) tick();
        check_reset_pins("reset_mid");
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        prev_pix = 0;
        tick();
        chk("restart_fs_early", 32'(bus.frame_start), 32'h0);
        tick();
        chk("restart_fs", 32'(bus.frame_start), 32'h1);
        repeat (3 * HT) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
